uart_axis_collector: RTL

Receives the bit-banged UART output of one SERV core and converts it into the AXI-Stream byte flow that feeds the emitter's i_tdata/i_tlast/i_tvalid/o_tready port.
Deserialises 8N1 frames and buffers bytes in a small FIFO. Each newline byte is marked as the last beat of a packet.
One instance sits between each core's UART line and the stream arbiter in front of the emitter.

---
 rtl/uart_collector_pkg.sv | 20 ++
 rtl/collector_fifo.sv | 57 +++++
 rtl/uart_axis_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_collector_pkg.sv
// Shared types and frame constants for the UART-to-AXI-Stream collector.
package uart_collector_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/collector_fifo.sv
// Small synchronous FIFO of {last, data} entries. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module collector_fifo
  import uart_collector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t din,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_axis_collector.sv
// Deserialises 8N1 UART frames from a core's TX line and presents the bytes
// as an AXI-Stream; a TLAST_CHAR byte closes a packet.
// Optional build macro UART_COLLECTOR_ERRCNT_EN adds o_err_cnt, a saturating
// count of framing errors.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB first
// STOP  | sampling the stop bit, push on success
// BREAK | framing error seen, wait for the line to return high
module uart_axis_collector
  import uart_collector_pkg::*;
#(
  parameter int         BAUD_DIV   = 16,
  parameter int         DEPTH      = 4,
  parameter logic [7:0] TLAST_CHAR = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_overflow
`ifdef UART_COLLECTOR_ERRCNT_EN
  ,
  output logic [7:0] o_err_cnt
`endif
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t   state, state_next;
  logic        rx_meta, rx_s;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [7:0]  shreg;
  logic        shift_en;
  logic        baud_zero;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  fifo_entry_t head;
  fifo_entry_t din;

  assign baud_zero = (baud_cnt == '0);
  assign din.last  = (shreg == TLAST_CHAR);
  assign din.data  = shreg;
  assign pop       = o_tvalid & i_tready;

  // Two-flop synchroniser; idles high so reset looks like a quiet line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // State register plus the bit timing counters and shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // Next-state, counter reloads and the push strobe.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_en   = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          baud_next  = BAUD_HALF;
          state_next = START;
        end
      end
      START: begin
        if (!baud_zero) begin
          baud_next = baud_cnt - BW'(1);
        end else if (!rx_s) begin
          baud_next  = BAUD_FULL;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (!baud_zero) begin
          baud_next = baud_cnt - BW'(1);
        end else begin
          shift_en  = 1'b1;
          baud_next = BAUD_FULL;
          if (bit_cnt == LAST_BIT) state_next = STOP;
          else                     bit_next   = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (!baud_zero) begin
          baud_next = baud_cnt - BW'(1);
        end else if (rx_s) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  collector_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Head is gated so the stream outputs read zero while nothing is queued.
  assign o_tvalid = ~empty;
  assign o_tdata  = o_tvalid ? head.data : 8'h00;
  assign o_tlast  = o_tvalid & head.last;

  // Sticky drop flag: push into a full FIFO with no pop in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)                     o_overflow <= 1'b0;
    else if (push & full & ~pop)   o_overflow <= 1'b1;
  end

`ifdef UART_COLLECTOR_ERRCNT_EN
  logic frame_err;
  assign frame_err = (state == STOP) & baud_zero & ~rx_s;

  // Saturating framing-error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                o_err_cnt <= 8'h00;
    else if (frame_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
  end
`endif

endmodule
